// File: rtl/jtcop_snd_pkg.sv
// Shared types for the sound-domain ROM arbiter.
// FSM states, owner encoding and the default ADPCM base.
package jtcop_snd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_st_t;

  typedef enum logic {
    OWN_SND = 1'b0,
    OWN_PCM = 1'b1
  } arb_own_t;

  localparam logic [18:0] PCM_OFFSET_DEF = 19'h10000;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/jtcop_romarb_cache.sv
// One-entry read cache: tag, data and valid bit.
// Hit compare is combinational; fills come from the arbiter.
module jtcop_romarb_cache #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cs,
  input  logic [AW-1:0] i_addr,
  input  logic          i_wr,
  input  logic [AW-1:0] i_wtag,
  input  logic [7:0]    i_wdata,
  output logic          o_ok,
  output logic          o_miss,
  output logic [7:0]    o_data
);

  logic          r_valid;
  logic [AW-1:0] r_tag;
  logic [7:0]    r_data;
  logic          w_hit;

  assign w_hit  = r_valid & (i_addr == r_tag);
  assign o_ok   = i_cs & w_hit;
  assign o_miss = i_cs & ~w_hit;
  assign o_data = r_data;

  // Store the fetched byte under the address latched at grant time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= 8'd0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
      r_tag   <= i_wtag;
      r_data  <= i_wdata;
    end
  end

endmodule

// File: rtl/jtcop_snd_romarb.sv
// Shares one SDRAM ROM channel between sound CPU and ADPCM.
// Optional hit/miss counters: define JTCOP_ROMARB_STATS_EN.
module jtcop_snd_romarb
  import jtcop_snd_pkg::*;
#(
  parameter int SND_AW = 16,
  parameter int PCM_AW = 18,
  parameter int OUT_AW = 19,
  parameter logic [OUT_AW-1:0] PCM_OFFSET =
    OUT_AW'(PCM_OFFSET_DEF)
) (
  input  logic              clk24,
  input  logic              rst24,
  input  logic              snd_cs,
  input  logic [SND_AW-1:0] snd_addr,
  output logic [7:0]        snd_data,
  output logic              snd_ok,
  input  logic              adpcm_cs,
  input  logic [PCM_AW-1:0] adpcm_addr,
  output logic [7:0]        adpcm_data,
  output logic              adpcm_ok,
  output logic              rom_cs,
  output logic [OUT_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok,
  input  logic [7:0]        st_addr,
  output logic [7:0]        st_dout
);

  arb_st_t           r_st;
  arb_own_t          r_own;
  logic              r_fair;
  logic              r_rom_cs;
  logic [OUT_AW-1:0] r_rom_addr;
  logic [SND_AW-1:0] r_snd_lat;
  logic [PCM_AW-1:0] r_pcm_lat;

  logic              w_snd_ok;
  logic              w_snd_miss;
  logic              w_pcm_ok;
  logic              w_pcm_miss;
  logic              w_any_miss;
  logic              w_grant_pcm;
  logic              w_fill;
  logic              w_fill_snd;
  logic              w_fill_pcm;
  logic [OUT_AW-1:0] w_snd_rom;
  logic [OUT_AW-1:0] w_pcm_rom;
  logic              w_unused_st;

  assign w_snd_rom = OUT_AW'(snd_addr);
  assign w_pcm_rom = PCM_OFFSET + OUT_AW'(adpcm_addr);

  assign w_any_miss  = w_snd_miss | w_pcm_miss;
  assign w_grant_pcm = w_pcm_miss & (~w_snd_miss | r_fair);

  assign w_fill     = (r_st == WAIT) & rom_ok;
  assign w_fill_snd = w_fill & (r_own == OWN_SND);
  assign w_fill_pcm = w_fill & (r_own == OWN_PCM);

  assign snd_ok   = w_snd_ok;
  assign adpcm_ok = w_pcm_ok;
  assign rom_cs   = r_rom_cs;
  assign rom_addr = r_rom_addr;

  jtcop_romarb_cache #(
    .AW (SND_AW)
  ) u_snd (
    .clk     (clk24),
    .rst     (rst24),
    .i_cs    (snd_cs),
    .i_addr  (snd_addr),
    .i_wr    (w_fill_snd),
    .i_wtag  (r_snd_lat),
    .i_wdata (rom_data),
    .o_ok    (w_snd_ok),
    .o_miss  (w_snd_miss),
    .o_data  (snd_data)
  );

  jtcop_romarb_cache #(
    .AW (PCM_AW)
  ) u_pcm (
    .clk     (clk24),
    .rst     (rst24),
    .i_cs    (adpcm_cs),
    .i_addr  (adpcm_addr),
    .i_wr    (w_fill_pcm),
    .i_wtag  (r_pcm_lat),
    .i_wdata (rom_data),
    .o_ok    (w_pcm_ok),
    .o_miss  (w_pcm_miss),
    .o_data  (adpcm_data)
  );

  // Grant one miss at a time; REQ skips a possibly stale rom_ok
  always_ff @(posedge clk24 or posedge rst24) begin
    if (rst24) begin
      r_st       <= IDLE;
      r_own      <= OWN_SND;
      r_fair     <= 1'b0;
      r_rom_cs   <= 1'b0;
      r_rom_addr <= '0;
      r_snd_lat  <= '0;
      r_pcm_lat  <= '0;
    end else begin
      unique case (r_st)
        IDLE: begin
          if (w_any_miss) begin
            r_st     <= REQ;
            r_rom_cs <= 1'b1;
            if (w_grant_pcm) begin
              r_own      <= OWN_PCM;
              r_rom_addr <= w_pcm_rom;
              r_pcm_lat  <= adpcm_addr;
              r_fair     <= 1'b0;
            end else begin
              r_own      <= OWN_SND;
              r_rom_addr <= w_snd_rom;
              r_snd_lat  <= snd_addr;
              if (w_pcm_miss) r_fair <= 1'b1;
            end
          end
        end
        REQ: begin
          r_st <= WAIT;
        end
        WAIT: begin
          if (rom_ok) begin
            r_st     <= IDLE;
            r_rom_cs <= 1'b0;
          end
        end
        default: begin
          r_st     <= IDLE;
          r_rom_cs <= 1'b0;
        end
      endcase
    end
  end

`ifdef JTCOP_ROMARB_STATS_EN

  logic              r_snd_cs_d;
  logic              r_pcm_cs_d;
  logic [SND_AW-1:0] r_snd_addr_d;
  logic [PCM_AW-1:0] r_pcm_addr_d;
  logic [15:0]       r_snd_hit;
  logic [15:0]       r_snd_mis;
  logic [15:0]       r_pcm_hit;
  logic [15:0]       r_pcm_mis;
  logic [7:0]        r_st_dout;
  logic              w_snd_hit_ev;
  logic              w_pcm_hit_ev;
  logic              w_snd_grant;
  logic              w_pcm_grant;

  // A hit counts once per new request, not on a fill
  assign w_snd_hit_ev = w_snd_ok &
    (~r_snd_cs_d | (snd_addr != r_snd_addr_d));
  assign w_pcm_hit_ev = w_pcm_ok &
    (~r_pcm_cs_d | (adpcm_addr != r_pcm_addr_d));

  assign w_snd_grant = (r_st == IDLE) & w_any_miss &
    ~w_grant_pcm;
  assign w_pcm_grant = (r_st == IDLE) & w_grant_pcm;

  // Track previous request to detect new hit events
  always_ff @(posedge clk24 or posedge rst24) begin
    if (rst24) begin
      r_snd_cs_d   <= 1'b0;
      r_pcm_cs_d   <= 1'b0;
      r_snd_addr_d <= '0;
      r_pcm_addr_d <= '0;
    end else begin
      r_snd_cs_d   <= snd_cs;
      r_pcm_cs_d   <= adpcm_cs;
      r_snd_addr_d <= snd_addr;
      r_pcm_addr_d <= adpcm_addr;
    end
  end

  // Saturating hit and miss counters
  always_ff @(posedge clk24 or posedge rst24) begin
    if (rst24) begin
      r_snd_hit <= 16'd0;
      r_snd_mis <= 16'd0;
      r_pcm_hit <= 16'd0;
      r_pcm_mis <= 16'd0;
    end else begin
      if (w_snd_hit_ev) r_snd_hit <= sat_inc(r_snd_hit);
      if (w_snd_grant)  r_snd_mis <= sat_inc(r_snd_mis);
      if (w_pcm_hit_ev) r_pcm_hit <= sat_inc(r_pcm_hit);
      if (w_pcm_grant)  r_pcm_mis <= sat_inc(r_pcm_mis);
    end
  end

  // Registered little-endian byte readout
  always_ff @(posedge clk24 or posedge rst24) begin
    if (rst24) begin
      r_st_dout <= 8'd0;
    end else begin
      unique case (st_addr[2:0])
        3'd0: r_st_dout <= r_snd_hit[7:0];
        3'd1: r_st_dout <= r_snd_hit[15:8];
        3'd2: r_st_dout <= r_snd_mis[7:0];
        3'd3: r_st_dout <= r_snd_mis[15:8];
        3'd4: r_st_dout <= r_pcm_hit[7:0];
        3'd5: r_st_dout <= r_pcm_hit[15:8];
        3'd6: r_st_dout <= r_pcm_mis[7:0];
        3'd7: r_st_dout <= r_pcm_mis[15:8];
      endcase
    end
  end

  assign st_dout     = r_st_dout;
  assign w_unused_st = ^st_addr[7:3];

`else

  assign st_dout     = 8'd0;
  assign w_unused_st = ^st_addr;

`endif

endmodule

// File: tb/tb_jtcop_snd_romarb.sv
// Scoreboard bench for the sound ROM arbiter.
// Fetch and data monitors pop expectations pushed by stimulus.
module tb_jtcop_snd_romarb;

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  data;
  } rd_t;

  typedef struct {
    logic [18:0] addr;
    int          gap;
  } fe_t;

  logic        clk24;
  logic        rst24;
  logic        snd_cs;
  logic [15:0] snd_addr;
  logic [7:0]  snd_data;
  logic        snd_ok;
  logic        adpcm_cs;
  logic [17:0] adpcm_addr;
  logic [7:0]  adpcm_data;
  logic        adpcm_ok;
  logic        rom_cs;
  logic [18:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic [7:0]  st_addr;
  logic [7:0]  st_dout;

  int  n_checks = 0;
  int  n_errors = 0;
  int  lat      = 2;
  bit  stale    = 0;
  bit  man      = 0;
  bit  man_ok   = 0;
  logic [7:0] man_data = 8'h00;

  rd_t exp_snd[$];
  rd_t exp_pcm[$];
  fe_t exp_fetch[$];

  jtcop_snd_romarb dut (
    .clk24      (clk24),
    .rst24      (rst24),
    .snd_cs     (snd_cs),
    .snd_addr   (snd_addr),
    .snd_data   (snd_data),
    .snd_ok     (snd_ok),
    .adpcm_cs   (adpcm_cs),
    .adpcm_addr (adpcm_addr),
    .adpcm_data (adpcm_data),
    .adpcm_ok   (adpcm_ok),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_ok     (rom_ok),
    .st_addr    (st_addr),
    .st_dout    (st_dout)
  );

  initial begin
    clk24 = 1'b0;
    forever #5 clk24 = ~clk24;
  end

  function automatic logic [7:0] mem(input logic [18:0] a);
    if (a == 19'h00123) return 8'hA5;
    return a[7:0] ^ 8'h3C;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // SDRAM slot model
  initial begin
    int cnt;
    cnt = 0;
    rom_ok = 1'b0;
    rom_data = 8'h00;
    forever begin
      @(posedge clk24); #1;
      if (man) begin
        rom_ok = man_ok;
        rom_data = man_data;
        cnt = 0;
      end else if (rom_cs) begin
        if (cnt == lat) begin
          rom_ok = 1'b1;
          rom_data = mem(rom_addr);
        end else if (!stale) begin
          rom_ok = 1'b0;
        end
        cnt++;
      end else begin
        cnt = 0;
        if (stale) begin
          rom_ok = 1'b1;
          rom_data = 8'hEE;
        end else begin
          rom_ok = 1'b0;
        end
      end
    end
  end

  // Fetch monitor: grant order, address, gap, stability
  initial begin
    logic        last;
    logic [18:0] held;
    int          low;
    fe_t         e;
    last = 1'b0;
    held = '0;
    low = 0;
    forever begin
      @(negedge clk24);
      if (rom_cs && !last) begin
        if (exp_fetch.size() == 0) begin
          chk("unexpected_fetch", 32'(rom_addr), 32'h7FFFF);
        end else begin
          e = exp_fetch.pop_front();
          chk("fetch_addr", 32'(rom_addr), 32'(e.addr));
          if (e.gap >= 0) chk("fetch_gap", 32'(low), 32'(e.gap));
        end
        held = rom_addr;
      end else if (rom_cs) begin
        chk("fetch_hold", 32'(rom_addr), 32'(held));
      end
      if (rom_cs) low = 0;
      else low++;
      last = rom_cs;
    end
  end

  // Sound data monitor
  initial begin
    bit          seen;
    logic [15:0] a;
    rd_t         e;
    seen = 0;
    a = '0;
    forever begin
      @(negedge clk24);
      if (snd_cs && snd_ok) begin
        if (!seen || snd_addr != a) begin
          seen = 1;
          a = snd_addr;
          if (exp_snd.size() == 0) begin
            chk("unexpected_snd_ok", 32'(snd_addr), 32'hFFFFF);
          end else begin
            e = exp_snd.pop_front();
            chk("snd_addr", 32'(snd_addr), 32'(e.addr));
            chk("snd_data", 32'(snd_data), 32'(e.data));
          end
        end
      end else begin
        seen = 0;
      end
    end
  end

  // ADPCM data monitor
  initial begin
    bit          seen;
    logic [17:0] a;
    rd_t         e;
    seen = 0;
    a = '0;
    forever begin
      @(negedge clk24);
      if (adpcm_cs && adpcm_ok) begin
        if (!seen || adpcm_addr != a) begin
          seen = 1;
          a = adpcm_addr;
          if (exp_pcm.size() == 0) begin
            chk("unexpected_pcm_ok", 32'(adpcm_addr), 32'hFFFFF);
          end else begin
            e = exp_pcm.pop_front();
            chk("pcm_addr", 32'(adpcm_addr), 32'(e.addr));
            chk("pcm_data", 32'(adpcm_data), 32'(e.data));
          end
        end
      end else begin
        seen = 0;
      end
    end
  end

  task automatic wait_cs_rise();
    logic last;
    int   n;
    last = rom_cs;
    n = 0;
    forever begin
      @(negedge clk24);
      if (rom_cs && !last) break;
      last = rom_cs;
      n++;
      if (n > 60) begin
        chk("cs_rise_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  task automatic wait_ok(input bit pcm, output int l);
    l = 0;
    forever begin
      @(negedge clk24);
      if (pcm ? adpcm_ok : snd_ok) break;
      l++;
      if (l > 80) begin
        chk(pcm ? "pcm_ok_timeout" : "snd_ok_timeout",
            32'(l), 32'd0);
        break;
      end
    end
  endtask

  task automatic snd_req(input logic [15:0] a, input bit fe,
                         input int xl, input logic [7:0] d);
    int l;
    @(posedge clk24); #1;
    if (fe) exp_fetch.push_back('{19'(a), -1});
    exp_snd.push_back('{19'(a), d});
    snd_cs = 1'b1;
    snd_addr = a;
    wait_ok(1'b0, l);
    if (xl >= 0) chk("snd_latency", 32'(l), 32'(xl));
    @(posedge clk24); #1;
    snd_cs = 1'b0;
  endtask

  task automatic pcm_req(input logic [17:0] a,
                         input logic [18:0] ra,
                         input logic [7:0] d);
    int l;
    @(posedge clk24); #1;
    exp_fetch.push_back('{ra, -1});
    exp_pcm.push_back('{19'(a), d});
    adpcm_cs = 1'b1;
    adpcm_addr = a;
    wait_ok(1'b1, l);
    chk("pcm_latency", 32'(l), 32'd4);
    @(posedge clk24); #1;
    adpcm_cs = 1'b0;
  endtask

  task automatic st_read(input logic [7:0] a,
                         input logic [7:0] e);
    @(posedge clk24); #1;
    st_addr = a;
    @(posedge clk24);
    @(negedge clk24);
    chk($sformatf("st_dout_%0d", a), 32'(st_dout), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    rst24 = 1'b1;
    snd_cs = 1'b0;
    snd_addr = '0;
    adpcm_cs = 1'b0;
    adpcm_addr = '0;
    st_addr = 8'd0;
    repeat (3) @(posedge clk24);
    @(negedge clk24);
    chk("rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_snd_ok", 32'(snd_ok), 32'd0);
    chk("rst_pcm_ok", 32'(adpcm_ok), 32'd0);
    chk("rst_snd_data", 32'(snd_data), 32'd0);
    chk("rst_pcm_data", 32'(adpcm_data), 32'd0);
    chk("rst_st_dout", 32'(st_dout), 32'd0);
    @(posedge clk24); #1;
    rst24 = 1'b0;

    // cold miss then hit
    snd_req(16'h0123, 1, 4, 8'hA5);
    snd_req(16'h0123, 0, 0, 8'hA5);

    // ADPCM mapping
    pcm_req(18'h3FFFF, 19'h4FFFF, 8'hC3);
    pcm_req(18'h00010, 19'h10010, 8'h2C);

    // both missing: snd, pcm, snd, then pcm
    @(posedge clk24); #1;
    exp_fetch.push_back('{19'h00200, -1});
    exp_fetch.push_back('{19'h10300, 1});
    exp_fetch.push_back('{19'h00201, 1});
    exp_fetch.push_back('{19'h10301, 1});
    exp_snd.push_back('{19'h00201, 8'h3D});
    exp_pcm.push_back('{19'h00301, 8'h3D});
    snd_cs = 1'b1;
    snd_addr = 16'h0200;
    adpcm_cs = 1'b1;
    adpcm_addr = 18'h00300;
    wait_cs_rise();
    @(posedge clk24); #1;
    snd_addr = 16'h0201;
    wait_cs_rise();
    @(posedge clk24); #1;
    adpcm_addr = 18'h00301;
    wait_ok(1'b0, l);
    wait_ok(1'b1, l);
    @(posedge clk24); #1;
    snd_cs = 1'b0;
    adpcm_cs = 1'b0;

    // address change during WAIT
    @(posedge clk24); #1;
    exp_fetch.push_back('{19'h00010, -1});
    exp_fetch.push_back('{19'h00020, 1});
    exp_snd.push_back('{19'h00020, 8'h1C});
    snd_cs = 1'b1;
    snd_addr = 16'h0010;
    wait_cs_rise();
    @(posedge clk24); #1;
    snd_addr = 16'h0020;
    wait_ok(1'b0, l);
    @(posedge clk24); #1;
    snd_cs = 1'b0;

    // stale rom_ok held high across fetch start
    lat = 1;
    stale = 1;
    repeat (3) @(posedge clk24);
    snd_req(16'h0400, 1, 3, 8'h3C);
    stale = 0;
    lat = 2;

    // reset during WAIT
    @(posedge clk24); #1;
    exp_pcm.push_back('{19'h00301, 8'h3D});
    adpcm_cs = 1'b1;
    adpcm_addr = 18'h00301;
    @(negedge clk24);
    chk("pcm_hit_pre_rst", 32'(adpcm_ok), 32'd1);
    @(posedge clk24); #1;
    exp_fetch.push_back('{19'h00500, -1});
    snd_cs = 1'b1;
    snd_addr = 16'h0500;
    wait_cs_rise();
    @(posedge clk24); #1;
    rst24 = 1'b1;
    #1;
    chk("midrst_rom_cs", 32'(rom_cs), 32'd0);
    chk("midrst_snd_ok", 32'(snd_ok), 32'd0);
    chk("midrst_pcm_ok", 32'(adpcm_ok), 32'd0);
    snd_cs = 1'b0;
    adpcm_cs = 1'b0;
    man = 1;
    man_ok = 1;
    man_data = 8'h77;
    @(posedge clk24); #1;
    rst24 = 1'b0;
    repeat (3) @(posedge clk24);
    #1;
    snd_cs = 1'b1;
    snd_addr = 16'h0000;
    adpcm_cs = 1'b1;
    adpcm_addr = 18'h00000;
    @(negedge clk24);
    chk("late_ok_snd", 32'(snd_ok), 32'd0);
    chk("late_ok_pcm", 32'(adpcm_ok), 32'd0);
    #1;
    snd_cs = 1'b0;
    adpcm_cs = 1'b0;
    @(posedge clk24); #1;
    man = 0;
    man_ok = 0;
    exp_fetch.push_back('{19'h00500, -1});
    exp_fetch.push_back('{19'h10301, 1});
    exp_snd.push_back('{19'h00500, 8'h3C});
    exp_pcm.push_back('{19'h00301, 8'h3D});
    snd_cs = 1'b1;
    snd_addr = 16'h0500;
    adpcm_cs = 1'b1;
    adpcm_addr = 18'h00301;
    wait_ok(1'b0, l);
    wait_ok(1'b1, l);
    @(posedge clk24); #1;
    snd_cs = 1'b0;
    adpcm_cs = 1'b0;

    // statistics: 3 misses, 5 hits
    @(posedge clk24); #1;
    rst24 = 1'b1;
    @(posedge clk24); #1;
    rst24 = 1'b0;
    snd_req(16'h0600, 1, 4, 8'h3C);
    snd_req(16'h0601, 1, 4, 8'h3D);
    snd_req(16'h0602, 1, 4, 8'h3E);
    for (int i = 0; i < 5; i++) snd_req(16'h0602, 0, 0, 8'h3E);
`ifdef JTCOP_ROMARB_STATS_EN
    st_read(8'd0, 8'h05);
    st_read(8'd1, 8'h00);
    st_read(8'd2, 8'h03);
    st_read(8'd3, 8'h00);
    st_read(8'd4, 8'h00);
    st_read(8'd6, 8'h00);
`else
    st_read(8'd0, 8'h00);
    st_read(8'd2, 8'h00);
`endif

    repeat (5) @(posedge clk24);
    @(negedge clk24);
    chk("left_fetch", 32'(exp_fetch.size()), 32'd0);
    chk("left_snd", 32'(exp_snd.size()), 32'd0);
    chk("left_pcm", 32'(exp_pcm.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
